// File: rtl/key_debounce_module.sv
// key_debounce_module: two-flop synchroniser and confirm-counter debouncer for an
// active-low push-button. It produces a clean level, one-cycle press/release
// strobes, a once-per-press long-press strobe and a wrapping press counter.
module key_debounce_module #(
  parameter logic [15:0] T_DEBOUNCE = 16'd50,  // 2..65535 identical samples to accept a level
  parameter logic [15:0] T_LONG     = 16'd1000 // 1..65535 pressed cycles before Key_Long
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Key_In,
  output logic       Key_Out,
  output logic       Key_Press,
  output logic       Key_Release,
  output logic       Key_Long,
  output logic [3:0] Press_Cnt,
  output logic       dbg_state    // 1 while the FSM is confirming a candidate level
);

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic [15:0] db_cnt;
  logic [15:0] long_cnt;
  logic        long_done;
  logic        commit;
  logic        release_commit;

  assign dbg_state = (state == CONFIRM);

  // Commit happens when the candidate level has been seen T_DEBOUNCE times in a row.
  always_comb begin
    commit         = 1'b0;
    release_commit = 1'b0;
    if (state == CONFIRM && s2 != Key_Out && db_cnt == T_DEBOUNCE - 16'd1) begin
      commit         = 1'b1;
      release_commit = s2;
    end
  end

  // Two-flop synchroniser; idle level is 1 (released) so reset looks like "not pressed".
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= Key_In;
      s2 <= s1;
    end
  end

  // Debounce FSM with registered level, press/release strobes and press counter.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= STABLE;
      db_cnt      <= 16'd0;
      Key_Out     <= 1'b1;
      Key_Press   <= 1'b0;
      Key_Release <= 1'b0;
      Press_Cnt   <= 4'd0;
    end else begin
      Key_Press   <= 1'b0;
      Key_Release <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != Key_Out) begin
            state  <= CONFIRM;
            db_cnt <= 16'd1;
          end else begin
            db_cnt <= 16'd0;
          end
        end
        CONFIRM: begin
          if (s2 == Key_Out) begin
            // Bounced back before confirmation: drop the candidate silently.
            state  <= STABLE;
            db_cnt <= 16'd0;
          end else if (commit) begin
            Key_Out <= s2;
            state   <= STABLE;
            db_cnt  <= 16'd0;
            if (!s2) begin
              Key_Press <= 1'b1;
              Press_Cnt <= Press_Cnt + 4'd1;
            end else begin
              Key_Release <= 1'b1;
            end
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        default: begin
          state  <= STABLE;
          db_cnt <= 16'd0;
        end
      endcase
    end
  end

  // Long-press timer: saturating count while pressed, one strobe per press,
  // and a release committing this edge wins over a strobe due on the same edge.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      long_cnt  <= 16'd0;
      long_done <= 1'b0;
      Key_Long  <= 1'b0;
    end else begin
      Key_Long <= 1'b0;
      if (Key_Out || release_commit) begin
        long_cnt  <= 16'd0;
        long_done <= 1'b0;
      end else begin
        if (long_cnt != T_LONG) begin
          long_cnt <= long_cnt + 16'd1;
        end
        if (long_cnt == T_LONG - 16'd1 && !long_done) begin
          Key_Long  <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_module.sv
// Bench for key_debounce_module with T_DEBOUNCE=4, T_LONG=10: a per-cycle vector
// table for reset, bounce rejection and a clean press, then hand-written sequences
// for long press, release, short press, counter wrap and reset during confirm.
module tb_key_debounce_module;

  localparam logic [15:0] TD = 16'd4;
  localparam logic [15:0] TL = 16'd10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_in = 1'b1;
  logic       key_out;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic [3:0] press_cnt;
  logic       dbg_state;

  int total = 0;
  int bad = 0;
  int both_hi = 0;

  typedef struct {
    logic       k;
    logic       r;
    logic       o;
    logic       p;
    logic       rl;
    logic       l;
    logic [3:0] c;
  } vec_t;

  vec_t tbl[20];

  key_debounce_module #(.T_DEBOUNCE(TD), .T_LONG(TL)) dut (
    .CLK        (clk),
    .RSTn       (rstn),
    .Key_In     (key_in),
    .Key_Out    (key_out),
    .Key_Press  (key_press),
    .Key_Release(key_release),
    .Key_Long   (key_long),
    .Press_Cnt  (press_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // driver: apply inputs, take one edge, sample 1 time unit later
  task automatic step(input logic k, input logic r);
    key_in = k;
    rstn   = r;
    @(posedge clk);
    #1;
    if (key_press && key_release) both_hi++;
  endtask

  initial begin
    int long_n, long_at, rel_n, rel_at, pr_n, pr_at, fall_at;

    // reset rows, bounce 0,1,0,0,1,0, idle, then a clean press (e0..e6)
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 9; i < 13; i++)  tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 13; i < 18; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].k, tbl[i].r);
      check($sformatf("row%0d key_out", i), int'(key_out), int'(tbl[i].o));
      check($sformatf("row%0d press", i), int'(key_press), int'(tbl[i].p));
      check($sformatf("row%0d release", i), int'(key_release), int'(tbl[i].rl));
      check($sformatf("row%0d long", i), int'(key_long), int'(tbl[i].l));
      check($sformatf("row%0d press_cnt", i), int'(press_cnt), int'(tbl[i].c));
    end

    // long press: keep holding through e39; Key_Long expected once at e15
    long_n = 0; long_at = -1;
    for (int e = 7; e < 40; e++) begin
      step(1'b0, 1'b1);
      if (key_long) begin
        long_n++;
        if (long_at < 0) long_at = e;
      end
    end
    check("long_count", long_n, 1);
    check("long_edge", long_at, 15);
    check("held_key_out", int'(key_out), 0);

    // release: Key_Release TD+1 edges after Key_In rises
    rel_n = 0; rel_at = -1; pr_n = 0;
    for (int j = 0; j < 12; j++) begin
      step(1'b1, 1'b1);
      if (key_release) begin
        rel_n++;
        if (rel_at < 0) rel_at = j;
      end
      if (key_press) pr_n++;
    end
    check("release_count", rel_n, 1);
    check("release_edge", rel_at, 5);
    check("release_no_press", pr_n, 0);
    check("released_key_out", int'(key_out), 1);

    // short press: 8 cycles low, no Key_Long
    pr_n = 0; pr_at = -1; rel_n = 0; rel_at = -1; long_n = 0;
    for (int j = 0; j < 25; j++) begin
      step((j < 8) ? 1'b0 : 1'b1, 1'b1);
      if (key_press) begin pr_n++; if (pr_at < 0) pr_at = j; end
      if (key_release) begin rel_n++; if (rel_at < 0) rel_at = j; end
      if (key_long) long_n++;
    end
    check("short_press_count", pr_n, 1);
    check("short_press_edge", pr_at, 5);
    check("short_release_count", rel_n, 1);
    check("short_release_edge", rel_at, 13);
    check("short_no_long", long_n, 0);
    check("short_press_cnt", int'(press_cnt), 2);

    // wrap: reset, then 17 presses -> 1..15, 0, 1
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("reset_press_cnt", int'(press_cnt), 0);
    check("reset_key_out", int'(key_out), 1);
    pr_n = 0;
    for (int p = 0; p < 17; p++) begin
      for (int j = 0; j < 16; j++) begin
        step((j < 8) ? 1'b0 : 1'b1, 1'b1);
        if (key_press) begin
          pr_n++;
          check($sformatf("wrap_cnt_p%0d", p), int'(press_cnt), (p + 1) % 16);
        end
      end
    end
    check("wrap_press_pulses", pr_n, 17);

    // reset during confirm: after e3 the FSM is mid-confirm; reset at e4,e5
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("midrst_key_out", int'(key_out), 1);
    check("midrst_press_cnt", int'(press_cnt), 0);
    fall_at = -1;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b1);
      if (fall_at < 0 && key_out == 1'b0) fall_at = j;
    end
    check("midrst_fall_edge", fall_at, 5);
    check("midrst_press_cnt_after", int'(press_cnt), 1);

    check("never_both_strobes", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
